// File: rtl/noc_router.sv
`default_nettype none
// ============================================================================
// Module      : noc_router
// Description : CPU_NB x CPU_NB crossbar. Each input word is steered by its
//               destination byte [63:56] to a per-output round-robin arbiter
//               and output FIFO. Words with an out-of-range destination are
//               accepted immediately, discarded and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_router #(
    parameter int CPU_NB     = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CPU_NB-1:0]        data_cpu_to_noc_vld,
    input  logic [CPU_NB-1:0][63:0]  data_cpu_to_noc,
    output logic [CPU_NB-1:0]        data_cpu_to_noc_rdy,
    output logic [CPU_NB-1:0]        data_noc_to_cpu_vld,
    output logic [CPU_NB-1:0][63:0]  data_noc_to_cpu,
    input  logic [CPU_NB-1:0]        data_noc_to_cpu_rdy,
    output logic [31:0]              dropped_cnt
);

    localparam int                   C_IDX_W    = $clog2(CPU_NB);
    localparam int                   C_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                   C_CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0]           C_CPU_NB8  = 8'(CPU_NB);
    localparam logic [C_IDX_W-1:0]   C_IDX_LAST = C_IDX_W'(CPU_NB - 1);
    localparam logic [C_PTR_W-1:0]   C_PTR_LAST = C_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [C_CNT_W-1:0]   C_CNT_FULL = C_CNT_W'(FIFO_DEPTH);

    logic [CPU_NB-1:0]               w_in_valid;   // valid word, in-range destination
    logic [CPU_NB-1:0]               w_in_bad;     // valid word, out-of-range destination
    logic [CPU_NB-1:0][C_IDX_W-1:0]  w_dest_idx;
    logic [CPU_NB-1:0]               w_gnt_vld;
    logic [CPU_NB-1:0][C_IDX_W-1:0]  w_gnt_idx;
    logic [CPU_NB-1:0]               w_full;
    logic [CPU_NB-1:0]               w_accept;
    logic [CPU_NB-1:0][C_IDX_W-1:0]  r_rr;
    logic [6:0]                      w_drop_n;
    logic [32:0]                     w_drop_sum;
    logic [31:0]                     r_dropped_cnt;

    // Classify each input word by its destination byte.
    always_comb begin
        w_in_valid = '0;
        w_in_bad   = '0;
        w_dest_idx = '0;
        for (int i = 0; i < CPU_NB; i++) begin
            w_dest_idx[i] = data_cpu_to_noc[i][56 +: C_IDX_W];
            if (data_cpu_to_noc_vld[i]) begin
                if (data_cpu_to_noc[i][63:56] < C_CPU_NB8) begin
                    w_in_valid[i] = 1'b1;
                end else begin
                    w_in_bad[i] = 1'b1;
                end
            end
        end
    end

    // Per-output round-robin: first requester at or after r_rr, wrapping.
    always_comb begin
        int                 v_sum;
        logic [C_IDX_W-1:0] v_idx;
        w_gnt_vld = '0;
        w_gnt_idx = '0;
        v_sum     = 0;
        v_idx     = '0;
        for (int o = 0; o < CPU_NB; o++) begin
            for (int k = 0; k < CPU_NB; k++) begin
                v_sum = int'(r_rr[o]) + k;
                if (v_sum >= CPU_NB) begin
                    v_sum = v_sum - CPU_NB;
                end
                v_idx = C_IDX_W'(v_sum);
                if (!w_gnt_vld[o] && w_in_valid[v_idx] &&
                    (w_dest_idx[v_idx] == C_IDX_W'(o))) begin
                    w_gnt_vld[o] = 1'b1;
                    w_gnt_idx[o] = v_idx;
                end
            end
        end
    end

    // An output accepts its granted word only when its FIFO has room.
    always_comb begin
        w_accept = '0;
        for (int o = 0; o < CPU_NB; o++) begin
            w_accept[o] = rst_n && w_gnt_vld[o] && !w_full[o];
        end
    end

    // Input ready: granted with room, or an invalid word that is simply dropped.
    always_comb begin
        data_cpu_to_noc_rdy = '0;
        for (int i = 0; i < CPU_NB; i++) begin
            data_cpu_to_noc_rdy[i] = rst_n &&
                (w_in_bad[i] ||
                 (w_in_valid[i] && w_gnt_vld[w_dest_idx[i]] &&
                  (w_gnt_idx[w_dest_idx[i]] == C_IDX_W'(i)) &&
                  !w_full[w_dest_idx[i]]));
        end
    end

    // Advance each output's pointer past the input it just accepted from.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr <= '0;
        end else begin
            for (int o = 0; o < CPU_NB; o++) begin
                if (w_accept[o]) begin
                    r_rr[o] <= (w_gnt_idx[o] == C_IDX_LAST) ? '0 : w_gnt_idx[o] + 1'b1;
                end
            end
        end
    end

    // Number of invalid words discarded this cycle and the saturating sum.
    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < CPU_NB; i++) begin
            w_drop_n = w_drop_n + 7'(w_in_bad[i]);
        end
        w_drop_sum = {1'b0, r_dropped_cnt} + 33'(w_drop_n);
    end

    // Drop counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dropped_cnt <= '0;
        end else if (w_drop_n != '0) begin
            r_dropped_cnt <= w_drop_sum[32] ? '1 : w_drop_sum[31:0];
        end
    end

    assign dropped_cnt = r_dropped_cnt;

    generate
        for (genvar o = 0; o < CPU_NB; o++) begin : g_out
            logic [63:0]         r_mem [FIFO_DEPTH];
            logic [C_PTR_W-1:0]  r_wr_ptr;
            logic [C_PTR_W-1:0]  r_rd_ptr;
            logic [C_CNT_W-1:0]  r_count;
            logic                w_push;
            logic                w_pop;
            logic                w_empty;

            assign w_empty = (r_count == '0);
            assign w_push  = w_accept[o];
            assign w_pop   = !w_empty && data_noc_to_cpu_rdy[o];

            // Output FIFO: write the granted word, pop the head on transfer.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push) begin
                        r_mem[r_wr_ptr] <= data_cpu_to_noc[w_gnt_idx[o]];
                        r_wr_ptr        <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
                    end
                    if (w_push && !w_pop) begin
                        r_count <= r_count + 1'b1;
                    end else if (w_pop && !w_push) begin
                        r_count <= r_count - 1'b1;
                    end
                end
            end

            assign w_full[o]              = (r_count == C_CNT_FULL);
            assign data_noc_to_cpu_vld[o] = !w_empty;
            // Output data is forced to zero while empty so stale entries never show.
            assign data_noc_to_cpu[o]     = w_empty ? 64'd0 : r_mem[r_rd_ptr];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_noc_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_router
// Description : Directed self-checking bench for noc_router (CPU_NB=4,
//               FIFO_DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_router;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       in_vld;
    logic [3:0][63:0] in_data;
    logic [3:0]       in_rdy;
    logic [3:0]       out_vld;
    logic [3:0][63:0] out_data;
    logic [3:0]       out_rdy;
    logic [31:0]      dropped_cnt;

    int checks = 0;
    int errors = 0;

    noc_router #(.CPU_NB(4), .FIFO_DEPTH(2)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .data_cpu_to_noc_vld (in_vld),
        .data_cpu_to_noc     (in_data),
        .data_cpu_to_noc_rdy (in_rdy),
        .data_noc_to_cpu_vld (out_vld),
        .data_noc_to_cpu     (out_data),
        .data_noc_to_cpu_rdy (out_rdy),
        .dropped_cnt         (dropped_cnt)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        out_rdy = 4'b1111;
        in_vld  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_data[i] = {8'(i), 56'h11_2233_4455_6677};
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (in_rdy !== 4'b0000) begin
                $display("FAIL reset_in_rdy cycle %0d: got %b expected 0000", c, in_rdy);
                errors++;
            end
            checks++;
            if (out_vld !== 4'b0000) begin
                $display("FAIL reset_out_vld cycle %0d: got %b expected 0000", c, out_vld);
                errors++;
            end
            checks++;
            if (dropped_cnt !== 32'd0) begin
                $display("FAIL reset_dropped cycle %0d: got %h expected 0", c, dropped_cnt);
                errors++;
            end
            checks++;
        end
        if (out_data !== '0) begin
            $display("FAIL reset_out_data: got %h expected 0", out_data);
            errors++;
        end
        checks++;
        in_vld = 4'b0000;
        rst_n  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (out_vld !== 4'b0000) begin
                $display("FAIL post_reset_idle cycle %0d: got %b expected 0000", c, out_vld);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_single();
        in_data[1] = 64'h0200_0000_0000_ABCD;
        in_vld     = 4'b0010;
        #1;
        if (in_rdy !== 4'b0010) begin
            $display("FAIL single_rdy: got %b expected 0010", in_rdy);
            errors++;
        end
        checks++;
        tick();
        in_vld = 4'b0000;
        #1;
        if (out_vld !== 4'b0100) begin
            $display("FAIL single_out_vld: got %b expected 0100", out_vld);
            errors++;
        end
        checks++;
        if (out_data[2] !== 64'h0200_0000_0000_ABCD) begin
            $display("FAIL single_out_data: got %h expected 0200_0000_0000_ABCD", out_data[2]);
            errors++;
        end
        checks++;
        tick();
        if (out_vld !== 4'b0000) begin
            $display("FAIL single_drained: got %b expected 0000", out_vld);
            errors++;
        end
        checks++;
    endtask

    task automatic test_contention();
        logic [47:0] seq [4];
        logic [63:0] last;
        logic        have_last;
        int          ptr;
        ptr       = 0;
        have_last = 1'b0;
        last      = '0;
        for (int j = 0; j < 4; j++) begin
            seq[j]     = 48'd0;
            in_data[j] = {8'h00, 8'(j), 48'd0};
        end
        in_vld = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (in_rdy !== (4'b0001 << ptr)) begin
                $display("FAIL contention_grant cycle %0d: got %b expected %b",
                         c, in_rdy, 4'b0001 << ptr);
                errors++;
            end
            checks++;
            if (have_last) begin
                if (out_vld[0] !== 1'b1 || out_data[0] !== last) begin
                    $display("FAIL contention_out cycle %0d: got vld %b data %h expected 1 %h",
                             c, out_vld[0], out_data[0], last);
                    errors++;
                end
                checks++;
            end
            last      = in_data[ptr];
            have_last = 1'b1;
            tick();
            seq[ptr]     = seq[ptr] + 48'd1;
            in_data[ptr] = {8'h00, 8'(ptr), seq[ptr]};
            ptr          = (ptr + 1) % 4;
        end
        in_vld = 4'b0000;
        #1;
        if (out_data[0] !== last) begin
            $display("FAIL contention_last: got %h expected %h", out_data[0], last);
            errors++;
        end
        checks++;
        tick();
        if (out_vld !== 4'b0000) begin
            $display("FAIL contention_drained: got %b expected 0000", out_vld);
            errors++;
        end
        checks++;
    endtask

    task automatic test_backpressure();
        out_rdy    = 4'b0111;
        in_data[0] = 64'h0300_0000_0000_0A00;
        in_vld     = 4'b0001;
        #1;
        if (in_rdy[0] !== 1'b1) begin
            $display("FAIL bp_accept0: got %b expected 1", in_rdy[0]);
            errors++;
        end
        checks++;
        tick();
        in_data[0] = 64'h0300_0000_0000_0A01;
        #1;
        if (in_rdy[0] !== 1'b1) begin
            $display("FAIL bp_accept1: got %b expected 1", in_rdy[0]);
            errors++;
        end
        checks++;
        tick();
        in_data[0] = 64'h0300_0000_0000_0A02;
        #1;
        if (in_rdy[0] !== 1'b0) begin
            $display("FAIL bp_full_rdy: got %b expected 0", in_rdy[0]);
            errors++;
        end
        checks++;
        if (out_vld[3] !== 1'b1 || out_data[3] !== 64'h0300_0000_0000_0A00) begin
            $display("FAIL bp_head: got vld %b data %h expected 1 0300_0000_0000_0A00",
                     out_vld[3], out_data[3]);
            errors++;
        end
        checks++;
        tick();
        out_rdy = 4'b1111;
        #1;
        if (in_rdy[0] !== 1'b0) begin
            $display("FAIL bp_no_comb_path: got %b expected 0", in_rdy[0]);
            errors++;
        end
        checks++;
        tick();
        #1;
        if (in_rdy[0] !== 1'b1) begin
            $display("FAIL bp_resume_rdy: got %b expected 1", in_rdy[0]);
            errors++;
        end
        checks++;
        if (out_data[3] !== 64'h0300_0000_0000_0A01) begin
            $display("FAIL bp_pop1: got %h expected 0300_0000_0000_0A01", out_data[3]);
            errors++;
        end
        checks++;
        tick();
        in_vld = 4'b0000;
        #1;
        if (out_vld[3] !== 1'b1 || out_data[3] !== 64'h0300_0000_0000_0A02) begin
            $display("FAIL bp_pop2: got vld %b data %h expected 1 0300_0000_0000_0A02",
                     out_vld[3], out_data[3]);
            errors++;
        end
        checks++;
        tick();
        if (out_vld !== 4'b0000) begin
            $display("FAIL bp_drained: got %b expected 0000", out_vld);
            errors++;
        end
        checks++;
    endtask

    task automatic test_invalid_dest();
        in_data[2] = 64'h0700_0000_0000_1234;
        in_vld     = 4'b0100;
        #1;
        if (in_rdy !== 4'b0100) begin
            $display("FAIL inv_rdy: got %b expected 0100", in_rdy);
            errors++;
        end
        checks++;
        tick();
        in_vld = 4'b0000;
        #1;
        if (dropped_cnt !== 32'd1) begin
            $display("FAIL inv_count1: got %h expected 1", dropped_cnt);
            errors++;
        end
        checks++;
        if (out_vld !== 4'b0000) begin
            $display("FAIL inv_no_out: got %b expected 0000", out_vld);
            errors++;
        end
        checks++;
        in_data[0] = 64'hFF00_0000_0000_0001;
        in_data[1] = 64'h0400_0000_0000_0002;
        in_vld     = 4'b0011;
        #1;
        if (in_rdy !== 4'b0011) begin
            $display("FAIL inv_pair_rdy: got %b expected 0011", in_rdy);
            errors++;
        end
        checks++;
        tick();
        in_vld = 4'b0000;
        #1;
        if (dropped_cnt !== 32'd3) begin
            $display("FAIL inv_count3: got %h expected 3", dropped_cnt);
            errors++;
        end
        checks++;
        force dut.r_dropped_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_dropped_cnt;
        #1;
        if (dropped_cnt !== 32'hFFFF_FFFE) begin
            $display("FAIL inv_preload: got %h expected FFFFFFFE", dropped_cnt);
            errors++;
        end
        checks++;
        in_vld = 4'b0011;
        tick();
        in_vld = 4'b0000;
        #1;
        if (dropped_cnt !== 32'hFFFF_FFFF) begin
            $display("FAIL inv_saturate_pair: got %h expected FFFFFFFF", dropped_cnt);
            errors++;
        end
        checks++;
        in_vld = 4'b0001;
        tick();
        in_vld = 4'b0000;
        #1;
        if (dropped_cnt !== 32'hFFFF_FFFF) begin
            $display("FAIL inv_saturate_hold: got %h expected FFFFFFFF", dropped_cnt);
            errors++;
        end
        checks++;
        if (out_vld !== 4'b0000) begin
            $display("FAIL inv_no_out_sat: got %b expected 0000", out_vld);
            errors++;
        end
        checks++;
    endtask

    task automatic test_reset_mid_traffic();
        out_rdy    = 4'b1101;
        in_data[3] = 64'h0100_0000_0000_1111;
        in_vld     = 4'b1000;
        tick();
        in_data[3] = 64'h0100_0000_0000_2222;
        tick();
        in_vld = 4'b0000;
        #1;
        if (out_vld[1] !== 1'b1 || dut.g_out[1].r_count !== 2'd2) begin
            $display("FAIL mid_filled: got vld %b count %0d expected 1 2",
                     out_vld[1], dut.g_out[1].r_count);
            errors++;
        end
        checks++;
        rst_n      = 1'b0;
        in_data[0] = 64'h0900_0000_0000_0000;
        in_vld     = 4'b0001;
        #1;
        if (in_rdy !== 4'b0000) begin
            $display("FAIL mid_reset_rdy: got %b expected 0000", in_rdy);
            errors++;
        end
        checks++;
        tick();
        rst_n   = 1'b1;
        in_vld  = 4'b0000;
        out_rdy = 4'b1111;
        #1;
        if (out_vld !== 4'b0000 || dropped_cnt !== 32'd0) begin
            $display("FAIL mid_after_reset: got vld %b dropped %h expected 0000 0",
                     out_vld, dropped_cnt);
            errors++;
        end
        checks++;
        tick();
        if (out_vld !== 4'b0000) begin
            $display("FAIL mid_no_stale: got %b expected 0000", out_vld);
            errors++;
        end
        checks++;
        in_data[3] = 64'h0100_0000_0000_3333;
        in_vld     = 4'b1000;
        #1;
        if (in_rdy !== 4'b1000) begin
            $display("FAIL mid_new_rdy: got %b expected 1000", in_rdy);
            errors++;
        end
        checks++;
        tick();
        in_vld = 4'b0000;
        #1;
        if (out_vld !== 4'b0010 || out_data[1] !== 64'h0100_0000_0000_3333) begin
            $display("FAIL mid_new_out: got vld %b data %h expected 0010 0100_0000_0000_3333",
                     out_vld, out_data[1]);
            errors++;
        end
        checks++;
        tick();
        if (out_vld !== 4'b0000) begin
            $display("FAIL mid_drained: got %b expected 0000", out_vld);
            errors++;
        end
        checks++;
    endtask

    initial begin
        rst_n   = 1'b0;
        in_vld  = '0;
        in_data = '0;
        out_rdy = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_invalid_dest();
        test_reset_mid_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_router.md
# noc_router

Crossbar router at the NoC side of the CPU channels. It accepts 64-bit words from `CPU_NB` CPU ports on the cpu→noc valid/ready channels and steers each word by its destination field to the addressed CPU's noc→cpu channel. Each output has a round-robin arbiter and a small output FIFO. It is the responder end of the channels the CPU models (or their multisim servers) drive, and it drops straight into the `noc` slot of the top level.

## Interface
Parameters:
- `CPU_NB`, default 4: number of CPU ports, 2..64.
- `FIFO_DEPTH`, default 2: entries per output FIFO, ≥2.

Ports:
- `clk`  in  1: single clock, all logic on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `data_cpu_to_noc_vld`  in  1 ×`CPU_NB`: input word valid, per CPU.
- `data_cpu_to_noc`  in  64 ×`CPU_NB`: input word. Bits [63:56] are the destination CPU index.
- `data_cpu_to_noc_rdy`  out  1 ×`CPU_NB`: router accepts the input word.
- `data_noc_to_cpu_vld`  out  1 ×`CPU_NB`: output word valid, per destination CPU.
- `data_noc_to_cpu`  out  64 ×`CPU_NB`: output word, forwarded unmodified.
- `data_noc_to_cpu_rdy`  in  1 ×`CPU_NB`: destination CPU accepts the output word.
- `dropped_cnt`  out  32: count of words dropped for an invalid destination; saturates at 0xFFFF_FFFF.

## Operation
- **Transfer rule:** a transfer happens on a rising edge where `vld && rdy` are both high, on either channel.
- **Source obligations:** once a source raises `vld`, it holds `vld` and data stable until the transfer.
- **Destination decode:** `dest = data[63:56]`.
  - If `dest >= CPU_NB`, the word is invalid.
  - An invalid word gets `rdy=1` in the same cycle and is accepted and discarded.
  - Each discard increments `dropped_cnt` by 1.
  - An invalid word never touches any FIFO or arbiter.
- **Per-output arbitration:** each output o has a pointer `rr[o]`, reset value 0.
  - Candidates: inputs with `vld` high and a valid `dest == o`.
  - The grant goes to the first candidate at or after `rr[o]`, searching upward and wrapping modulo `CPU_NB`.
  - The grant is combinational from the current `vld`, `dest` and `rr`.
- **Input ready:** `data_cpu_to_noc_rdy[i]` is high when either:
  - i holds a valid word, i holds the grant of output `dest`, and that FIFO count < `FIFO_DEPTH`; or
  - i holds an invalid word.
  - `rdy` depends only on registered state and same-cycle inputs. There is no combinational path from `data_noc_to_cpu_rdy` to `data_cpu_to_noc_rdy`.
- **Pointer update:** on an accepted transfer into output o from input g, `rr[o] <= (g+1) mod CPU_NB`. With no accept, `rr[o]` holds.
- **Output FIFO:** `data_noc_to_cpu_vld[o]` = FIFO not empty; `data_noc_to_cpu[o]` = FIFO head.
  - The head pops on an output transfer.
  - Push and pop in the same cycle leave the count unchanged.
  - Each output accepts at most one word per cycle; different outputs operate in parallel.
- **Ordering:** words from one source to one destination are delivered in acceptance order. There is no ordering across sources.

## Timing
- **Reset values:** while `rst_n=0` at an edge, the following are cleared:
  - all FIFOs emptied, contents discarded;
  - all `rr` = 0;
  - `dropped_cnt` = 0;
  - every `data_noc_to_cpu_vld` = 0;
  - every `data_noc_to_cpu` = 0.
- **Inputs not ready during reset:** `data_cpu_to_noc_rdy` is forced to 0 throughout reset.
- **Reset mid-operation:** in-flight words are lost. No spurious output after reset.
- **Latency:** a word accepted at edge N into an empty FIFO shows `data_noc_to_cpu_vld=1` after edge N, visible in cycle N+1.
- **Throughput:** one word per cycle per output with `FIFO_DEPTH=2` and the destination continuously ready.
- **Full FIFO:** all inputs targeting that output see `rdy=0`. Accepts resume the cycle after a pop frees an entry.
- **`dropped_cnt` timing:** it updates at the edge of the discarding transfer, so the new value is visible the next cycle. Multiple invalid words in one cycle add their count, saturating.

## Test plan
- **Reset:** assert `rst_n=0` for 3 cycles with all inputs valid.
  - During reset: all `rdy`=0, all out `vld`=0, `dropped_cnt`=0.
  - After release: no output word until an input is accepted.
- **Single transfer:** CPU1 sends 0x0200_0000_0000_ABCD.
  - `rdy[1]`=1 in the same cycle.
  - `data_noc_to_cpu[2]`=0x0200_0000_0000_ABCD with `vld[2]`=1 the next cycle.
  - No other output is valid.
- **Contention:** CPUs 0-3 each continuously send words with dest 0; output 0 is always ready.
  - Accept order is 0,1,2,3,0,1,…, one word per cycle.
  - Each source's payload sequence arrives in order.
- **Backpressure:** hold `data_noc_to_cpu_rdy[3]=0`; CPU0 sends 3 words to dest 3.
  - Two are accepted, then `rdy[0]`=0.
  - Raise `rdy[3]`: words pop in order, and the third is accepted in the cycle after the first pop.
- **Invalid destination:** with `CPU_NB=4`, CPU2 sends dest 0x07.
  - `rdy[2]`=1 and the word is dropped.
  - `dropped_cnt` goes 0→1.
  - No output `vld` rises.
  - Preload the counter to 0xFFFF_FFFF: it stays saturated.
- **Reset mid-traffic:** fill output 1's FIFO, then pulse `rst_n=0` for 1 cycle.
  - `vld[1]`=0 after reset and the old words never appear.
  - The next word from CPU3 to dest 1 is delivered normally.
